// File: rtl/led_fx_pkg.sv
// led_fx_pkg
// Shared definitions for the LED fade engine:
//   - mode encodings driven on the `mode` input
//   - FSM state encodings
//   - calc_len(): ramp length L = max(1, max_idx >> shift)
package led_fx_pkg;

    typedef enum logic [1:0] {
        MODE_FADE_OUT = 2'd0,
        MODE_FADE_IN  = 2'd1,
        MODE_PULSE    = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_UP   = 2'd2
    } state_e;

    // A zero-length ramp is promoted to one level so the divider never sees 0.
    function automatic logic [31:0] calc_len(input logic [31:0] idx, input int shift);
        logic [31:0] shifted;
        shifted = idx >> shift;
        if (shifted == 32'd0) begin
            return 32'd1;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/led_channel_scaler.sv
// led_channel_scaler
// Combinational scaling of one colour channel: scaled = floor(color * level / len).
// Ports:
//   color  [CH_W-1:0]   latched channel intensity
//   level  [IDX_W-1:0]  current ramp level k (k <= len)
//   len    [IDX_W-1:0]  ramp length L
//   scaled [CH_W-1:0]   scaled intensity
module led_channel_scaler #(
    parameter int CH_W  = 8,
    parameter int IDX_W = 10
) (
    input  logic [CH_W-1:0]  color,
    input  logic [IDX_W-1:0] level,
    input  logic [IDX_W-1:0] len,
    output logic [CH_W-1:0]  scaled
);

    localparam int PROD_W = CH_W + IDX_W;

    logic [PROD_W-1:0] product_s;
    logic [PROD_W-1:0] divisor_s;

    // Multiply then divide; a zero length (only possible straight out of reset)
    // is forced to one so the quotient stays defined. Since level <= len the
    // quotient always fits in CH_W bits.
    always_comb begin
        product_s = {{IDX_W{1'b0}}, color} * {{CH_W{1'b0}}, level};
        if (len == {IDX_W{1'b0}}) begin
            divisor_s = {{(PROD_W-1){1'b0}}, 1'b1};
        end else begin
            divisor_s = {{CH_W{1'b0}}, len};
        end
        scaled = CH_W'(product_s / divisor_s);
    end

endmodule

// File: rtl/led_fade_engine.sv
// led_fade_engine
// Multi-channel linear LED fader. A trigger pulse latches colour, length and
// mode; the engine then walks a level counter k through the ramp, holding each
// level PRESCALE cycles, and drives cor_out = floor(C_ch * k / L) per channel.
// Ports:
//   clock    rising-edge system clock
//   reset    synchronous active-high reset
//   trigger  one-cycle start pulse (latches mode, cor_in, max_idx)
//   mode     0 fade-out, 1 fade-in, 2 pulse, 3 hold
//   cor_in   packed target colour, channel 0 in the MSBs
//   max_idx  duration source, L = max(1, max_idx >> LEN_SHIFT)
//   cor_out  registered current colour
//   busy     high while a ramp is running
//   done     one-cycle pulse at ramp (or hold load) completion
module led_fade_engine
    import led_fx_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int CH_W      = 8,
    parameter int IDX_W     = 10,
    parameter int LEN_SHIFT = 1,
    parameter int PRESCALE  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     trigger,
    input  logic [1:0]               mode,
    input  logic [CHANNELS*CH_W-1:0] cor_in,
    input  logic [IDX_W-1:0]         max_idx,
    output logic [CHANNELS*CH_W-1:0] cor_out,
    output logic                     busy,
    output logic                     done
);

    localparam int DATA_W = CHANNELS * CH_W;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_e             state_r, state_nx_s;
    mode_e              mode_r, mode_nx_s, mode_in_s;
    logic [DATA_W-1:0]  color_r, color_nx_s;
    logic [IDX_W-1:0]   len_r, len_nx_s, len_calc_s;
    logic [IDX_W-1:0]   level_r, level_nx_s, step_level_s;
    logic [PRE_W-1:0]   pre_r, pre_nx_s;
    logic [DATA_W-1:0]  cor_r, cor_nx_s, scaled_s;
    logic               busy_r, busy_nx_s;
    logic               done_r, done_nx_s;
    logic               step_s;

    assign mode_in_s  = mode_e'(mode);
    assign len_calc_s = IDX_W'(calc_len(32'(max_idx), LEN_SHIFT));
    // A level step happens on the last prescale cycle of a running ramp.
    assign step_s       = (state_r != ST_IDLE) && (pre_r == PRE_LAST);
    assign step_level_s = (state_r == ST_DOWN) ? (level_r - IDX_W'(1)) : (level_r + IDX_W'(1));

    // Per-channel scaling of the latched colour at the level about to be shown.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_scaler
        led_channel_scaler #(
            .CH_W  (CH_W),
            .IDX_W (IDX_W)
        ) u_scaler (
            .color  (color_r[CH_W*(CHANNELS-g)-1 -: CH_W]),
            .level  (step_level_s),
            .len    (len_r),
            .scaled (scaled_s[CH_W*(CHANNELS-g)-1 -: CH_W])
        );
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; a trigger always restarts, abandoning any ramp.
    always_comb begin
        state_nx_s = state_r;
        if (trigger) begin
            case (mode_in_s)
                MODE_FADE_OUT: state_nx_s = ST_DOWN;
                MODE_PULSE:    state_nx_s = ST_DOWN;
                MODE_FADE_IN:  state_nx_s = ST_UP;
                MODE_HOLD:     state_nx_s = ST_IDLE;
                default:       state_nx_s = ST_IDLE;
            endcase
        end else if (step_s) begin
            case (state_r)
                ST_DOWN: begin
                    if (step_level_s == {IDX_W{1'b0}}) begin
                        state_nx_s = (mode_r == MODE_PULSE) ? ST_UP : ST_IDLE;
                    end else begin
                        state_nx_s = ST_DOWN;
                    end
                end
                ST_UP: begin
                    if (step_level_s == len_r) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_UP;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Output/datapath next values: latches on trigger, level and prescaler
    // advance while running; busy/done follow the state being entered.
    always_comb begin
        mode_nx_s  = mode_r;
        color_nx_s = color_r;
        len_nx_s   = len_r;
        level_nx_s = level_r;
        pre_nx_s   = pre_r;
        cor_nx_s   = cor_r;
        busy_nx_s  = busy_r;
        done_nx_s  = 1'b0;
        if (trigger) begin
            mode_nx_s  = mode_in_s;
            color_nx_s = cor_in;
            len_nx_s   = len_calc_s;
            pre_nx_s   = {PRE_W{1'b0}};
            if (mode_in_s == MODE_FADE_IN) begin
                level_nx_s = {IDX_W{1'b0}};
                cor_nx_s   = {DATA_W{1'b0}};
            end else begin
                level_nx_s = len_calc_s;
                cor_nx_s   = cor_in;
            end
            busy_nx_s = (mode_in_s != MODE_HOLD);
            done_nx_s = (mode_in_s == MODE_HOLD);
        end else if (step_s) begin
            pre_nx_s   = {PRE_W{1'b0}};
            level_nx_s = step_level_s;
            cor_nx_s   = scaled_s;
            busy_nx_s  = (state_nx_s != ST_IDLE);
            done_nx_s  = (state_nx_s == ST_IDLE);
        end else if (state_r != ST_IDLE) begin
            pre_nx_s = pre_r + PRE_W'(1);
        end else begin
            pre_nx_s = pre_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r  <= MODE_FADE_OUT;
            color_r <= {DATA_W{1'b0}};
            len_r   <= {IDX_W{1'b0}};
            level_r <= {IDX_W{1'b0}};
            pre_r   <= {PRE_W{1'b0}};
            cor_r   <= {DATA_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            mode_r  <= mode_nx_s;
            color_r <= color_nx_s;
            len_r   <= len_nx_s;
            level_r <= level_nx_s;
            pre_r   <= pre_nx_s;
            cor_r   <= cor_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    assign cor_out = cor_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_led_fade_engine.sv
module tb_led_fade_engine;

    logic        clock;
    logic        reset;
    logic        trig1, trig3;
    logic [1:0]  mode;
    logic [23:0] cor_in;
    logic [9:0]  max_idx;
    logic [23:0] cor1, cor3;
    logic        busy1, busy3, done1, done3;

    int n_checks = 0;
    int n_fail   = 0;

    led_fade_engine #(.CHANNELS(3), .CH_W(8), .IDX_W(10), .LEN_SHIFT(1), .PRESCALE(1)) dut_p1 (
        .clock(clock), .reset(reset), .trigger(trig1), .mode(mode), .cor_in(cor_in),
        .max_idx(max_idx), .cor_out(cor1), .busy(busy1), .done(done1)
    );

    led_fade_engine #(.CHANNELS(3), .CH_W(8), .IDX_W(10), .LEN_SHIFT(1), .PRESCALE(3)) dut_p3 (
        .clock(clock), .reset(reset), .trigger(trig3), .mode(mode), .cor_in(cor_in),
        .max_idx(max_idx), .cor_out(cor3), .busy(busy3), .done(done3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: ramp length, step count and level n of the sequence.
    function automatic int ref_len(input logic [9:0] mi);
        int l;
        l = int'(mi) / 2;
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int ref_steps(input logic [1:0] md, input int l);
        case (md)
            2'd0, 2'd1: return l;
            2'd2:       return 2 * l;
            default:    return 0;
        endcase
    endfunction

    function automatic int ref_level(input logic [1:0] md, input int l, input int n);
        case (md)
            2'd0:    return l - n;
            2'd1:    return n;
            2'd2:    return (n <= l) ? (l - n) : (n - l);
            default: return l;
        endcase
    endfunction

    function automatic logic [23:0] ref_color(input logic [23:0] c, input int k, input int l);
        logic [23:0] r;
        int cv;
        for (int ch = 0; ch < 3; ch++) begin
            cv = int'(c[23-8*ch -: 8]);
            r[23-8*ch -: 8] = 8'((cv * k) / l);
        end
        return r;
    endfunction

    // Trigger one ramp on the chosen DUT and check every cycle until it settles.
    task automatic test_ramp(input int p, input logic [23:0] c, input logic [9:0] mi,
                             input logic [1:0] md, input string tag);
        int l, s, n;
        logic [23:0] exp_c, obs_c;
        logic exp_b, exp_d, obs_b, obs_d;
        l = ref_len(mi);
        s = ref_steps(md, l);
        @(negedge clock);
        cor_in = c; max_idx = mi; mode = md;
        if (p == 1) trig1 = 1'b1; else trig3 = 1'b1;
        @(negedge clock);
        trig1 = 1'b0; trig3 = 1'b0;
        for (int j = 0; j <= s * p + 2; j++) begin
            if (j > 0) @(negedge clock);
            n = j / p;
            if (n > s) n = s;
            exp_c = ref_color(c, ref_level(md, l, n), l);
            exp_b = (j < s * p);
            exp_d = (j == s * p);
            obs_c = (p == 1) ? cor1 : cor3;
            obs_b = (p == 1) ? busy1 : busy3;
            obs_d = (p == 1) ? done1 : done3;
            n_checks += 3;
            if (obs_c !== exp_c) begin
                n_fail++;
                $display("FAIL %s cor_out j=%0d got %06h expected %06h", tag, j, obs_c, exp_c);
            end
            if (obs_b !== exp_b) begin
                n_fail++;
                $display("FAIL %s busy j=%0d got %b expected %b", tag, j, obs_b, exp_b);
            end
            if (obs_d !== exp_d) begin
                n_fail++;
                $display("FAIL %s done j=%0d got %b expected %b", tag, j, obs_d, exp_d);
            end
            // Non-trigger inputs must be ignored mid-ramp.
            cor_in = 24'($urandom); max_idx = 10'($urandom); mode = 2'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; trig1 = 1'b0; trig3 = 1'b0;
        mode = 2'd0; cor_in = 24'h0; max_idx = 10'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks += 2;
        if ({cor1, busy1, done1} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_p1 got %06h/%b/%b expected 000000/0/0", cor1, busy1, done1);
        end
        if ({cor3, busy3, done3} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_p3 got %06h/%b/%b expected 000000/0/0", cor3, busy3, done3);
        end
    endtask

    task automatic test_directed();
        test_ramp(1, 24'hFF8040, 10'd8, 2'd0, "fade_out_l4");
        test_ramp(3, 24'h00FF00, 10'd4, 2'd1, "fade_in_p3");
        test_ramp(1, 24'h808080, 10'd2, 2'd2, "pulse_l1");
        test_ramp(1, 24'h123456, 10'd0, 2'd0, "min_len_0");
        test_ramp(1, 24'h123456, 10'd1, 2'd0, "min_len_1");
        test_ramp(1, 24'hA5C3E7, 10'd5, 2'd3, "hold");
        test_ramp(3, 24'h40FF10, 10'd6, 2'd2, "pulse_p3");
    endtask

    task automatic test_retrigger();
        int l;
        logic [23:0] exp_c;
        @(negedge clock);
        cor_in = 24'hFF8040; max_idx = 10'd8; mode = 2'd0; trig1 = 1'b1;
        @(negedge clock);   // T+1
        trig1 = 1'b0;
        @(negedge clock);   // T+2: retrigger sampled at the next edge
        cor_in = 24'h0000FF; max_idx = 10'd8; mode = 2'd0; trig1 = 1'b1;
        @(negedge clock);   // T+3
        trig1 = 1'b0;
        l = 4;
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) @(negedge clock);
            exp_c = ref_color(24'h0000FF, l - ((j > l) ? l : j), l);
            n_checks += 2;
            if (cor1 !== exp_c) begin
                n_fail++;
                $display("FAIL retrigger cor_out j=%0d got %06h expected %06h", j, cor1, exp_c);
            end
            if (done1 !== (j == l)) begin
                n_fail++;
                $display("FAIL retrigger done j=%0d got %b expected %b", j, done1, (j == l));
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        cor_in = 24'hFFFFFF; max_idx = 10'd20; mode = 2'd2; trig1 = 1'b1; trig3 = 1'b1;
        @(negedge clock);
        trig1 = 1'b0; trig3 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1; trig1 = 1'b1; trig3 = 1'b1;
        @(negedge clock);
        reset = 1'b0; trig1 = 1'b0; trig3 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_checks += 2;
            if ({cor1, busy1, done1} !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_mid_p1 j=%0d got %06h/%b/%b expected 000000/0/0", j, cor1, busy1, done1);
            end
            if ({cor3, busy3, done3} !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_mid_p3 j=%0d got %06h/%b/%b expected 000000/0/0", j, cor3, busy3, done3);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            test_ramp(($urandom_range(0, 1) == 0) ? 1 : 3, 24'($urandom),
                      10'($urandom_range(0, 40)), 2'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_retrigger();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
